// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Requests 8-byte lines (two instructions) from
// the instruction cache, one request outstanding at a time, and hands the
// instructions of each line to the instruction buffer, up to N per cycle and
// never more than the buffer has room for. A squash redirects fetch to a new
// PC. A cache response that was already in flight when the squash arrived is
// dropped when it returns.
//
// Ports
//   clock, reset        : single clock, asynchronous active-high reset
//   open_entries        : free instruction-buffer slots this cycle
//   squash, squash_pc   : redirect request and word-aligned target
//   icache_req_valid    : line request valid
//   icache_req_addr     : line address, low three bits zero
//   icache_req_ready    : cache accepts the request this cycle
//   icache_resp_valid   : one-cycle pulse with line data
//   icache_resp_data    : [31:0] at addr+0, [63:32] at addr+4
//   out_insts           : packets to the buffer, entries >= num_accept zero
//   num_accept          : number of packets written this cycle
//   debug_state/pc      : present only when DEBUG is defined
// ---------------------------------------------------------------------------

`ifndef N
`define N 3
`endif
`ifndef INST_BUFF_DEPTH
`define INST_BUFF_DEPTH 8
`endif

package fetch_pkg;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] npc;
      logic        valid;
   } INST_PACKET;
endpackage

module fetch_unit #(
   parameter int          N        = `N,
   parameter int          DEPTH    = `INST_BUFF_DEPTH,
   parameter logic [31:0] RESET_PC = 32'h0,
   localparam int         CW       = $clog2(DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [CW-1:0]         open_entries,
   input  logic                  squash,
   input  logic [31:0]           squash_pc,
   output logic                  icache_req_valid,
   output logic [31:0]           icache_req_addr,
   input  logic                  icache_req_ready,
   input  logic                  icache_resp_valid,
   input  logic [63:0]           icache_resp_data,
   output fetch_pkg::INST_PACKET out_insts [DEPTH-1:0],
   output logic [CW-1:0]         num_accept
`ifdef DEBUG
   ,
   output logic [1:0]            debug_state,
   output logic [31:0]           debug_pc
`endif
);

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_WAIT    = 2'd1,
      S_DELIVER = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [1:0]        slot_q, slot_d;
   logic [1:0][31:0]  line_q, line_d;
   logic [CW-1:0]     avail;
   logic [CW-1:0]     accept;

   // Next-state logic. The PC always points at the next instruction to be
   // handed over, so the line address is just the PC with its low bits
   // cleared and the starting slot of a fresh line is pc[2].
   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      slot_d           = slot_q;
      line_d           = line_q;
      icache_req_valid = 1'b0;
      icache_req_addr  = {pc_q[31:3], 3'b000};
      accept           = '0;
      avail            = CW'(2) - CW'(slot_q);

      case (state_q)
         S_REQ: begin
            icache_req_valid = !squash && !reset;
            if (icache_req_valid && icache_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (icache_resp_valid) begin
               line_d[0] = icache_resp_data[31:0];
               line_d[1] = icache_resp_data[63:32];
               slot_d    = {1'b0, pc_q[2]};
               state_d   = S_DELIVER;
            end
         end
         S_DELIVER: begin
            // Hand over whatever is left of the line, limited by buffer
            // room and the per-cycle width. Zero room holds everything.
            accept = (open_entries < avail) ? open_entries : avail;
            if (accept > CW'(N)) begin
               accept = CW'(N);
            end
            pc_d   = pc_q + (32'(accept) << 2);
            slot_d = slot_q + 2'(accept);
            if (slot_d == 2'd2) begin
               state_d = S_REQ;
            end
         end
         S_DRAIN: begin
            if (icache_resp_valid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      // A redirect overrides everything. A request still in flight must be
      // waited out in DRAIN unless its response lands in this same cycle.
      if (squash) begin
         accept    = '0;
         pc_d      = squash_pc;
         slot_d    = 2'd0;
         line_d[0] = '0;
         line_d[1] = '0;
         if ((state_q == S_WAIT || state_q == S_DRAIN) && !icache_resp_valid) begin
            state_d = S_DRAIN;
         end else begin
            state_d = S_REQ;
         end
      end
   end

   // Build the packets for the instructions accepted this cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         out_insts[i] = '0;
         if (i < int'(accept)) begin
            out_insts[i].inst  = line_q[(i == 0) ? slot_q[0] : 1'b1];
            out_insts[i].pc    = pc_q + 32'(4 * i);
            out_insts[i].npc   = pc_q + 32'(4 * i + 4);
            out_insts[i].valid = 1'b1;
         end
      end
   end

   assign num_accept = accept;

`ifdef DEBUG
   assign debug_state = state_q;
   assign debug_pc    = pc_q;
`endif

   // State registers. Reset returns to REQ at RESET_PC without waiting for
   // a clock edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         slot_q  <= 2'd0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         slot_q  <= slot_d;
         line_q  <= line_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (N=3, DEPTH=8, RESET_PC=0). A queue-based
// model of the fetch stream predicts the outputs every cycle; directed
// scenarios add literal expectations for key cycles.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int N_P     = 3;
   localparam int DEPTH_P = 8;
   localparam int CW      = $clog2(DEPTH_P + 1);

   logic              clock;
   logic              reset;
   logic [CW-1:0]     open_entries;
   logic              squash;
   logic [31:0]       squash_pc;
   logic              icache_req_valid;
   logic [31:0]       icache_req_addr;
   logic              icache_req_ready;
   logic              icache_resp_valid;
   logic [63:0]       icache_resp_data;
   INST_PACKET        out_insts [DEPTH_P-1:0];
   logic [CW-1:0]     num_accept;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_unit #(.N(N_P), .DEPTH(DEPTH_P), .RESET_PC(32'h0)) dut (
      .clock             (clock),
      .reset             (reset),
      .open_entries      (open_entries),
      .squash            (squash),
      .squash_pc         (squash_pc),
      .icache_req_valid  (icache_req_valid),
      .icache_req_addr   (icache_req_addr),
      .icache_req_ready  (icache_req_ready),
      .icache_resp_valid (icache_resp_valid),
      .icache_resp_data  (icache_resp_data),
      .out_insts         (out_insts),
      .num_accept        (num_accept)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_output(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic INST_PACKET mk(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic [31:0] npc);
      INST_PACKET p;
      p.inst  = inst;
      p.pc    = pc;
      p.npc   = npc;
      p.valid = 1'b1;
      return p;
   endfunction

   // Model: a queue of fetched-but-undelivered instructions, the PC of the
   // next instruction in program order, and whether a cache request is in
   // flight (and whether its data must be thrown away).
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } m_item_t;

   m_item_t     m_q [$];
   logic [31:0] m_pc;
   bit          m_outstanding;
   bit          m_discard;
   bit          exp_valid;
   bit          pre_out;
   int          exp_num;
   logic [31:0] base;
   INST_PACKET  exp_pkt;

   // Compare the DUT against the model on every falling edge, then advance
   // the model by what the coming rising edge will do.
   always @(negedge clock) begin
      if (reset) begin
         check_output("reset req_valid", icache_req_valid, 1'b0);
         check_output("reset num_accept", num_accept, '0);
         for (int i = 0; i < DEPTH_P; i++) begin
            check_output($sformatf("reset out_insts[%0d]", i), out_insts[i], '0);
         end
         m_q.delete();
         m_pc          = 32'h0;
         m_outstanding = 1'b0;
         m_discard     = 1'b0;
      end else begin
         exp_valid = !squash && !m_outstanding && (m_q.size() == 0);
         exp_num   = 0;
         if (!squash) begin
            exp_num = m_q.size();
            if (int'(open_entries) < exp_num) exp_num = int'(open_entries);
            if (N_P < exp_num) exp_num = N_P;
         end
         check_output("cyc req_valid", icache_req_valid, exp_valid);
         if (exp_valid) begin
            check_output("cyc req_addr", icache_req_addr, {m_pc[31:3], 3'b000});
         end
         check_output("cyc num_accept", num_accept, exp_num);
         for (int i = 0; i < DEPTH_P; i++) begin
            exp_pkt = '0;
            if (i < exp_num) exp_pkt = mk(m_q[i].inst, m_q[i].pc, m_q[i].pc + 32'd4);
            check_output($sformatf("cyc out_insts[%0d]", i), out_insts[i], exp_pkt);
         end

         if (squash) begin
            m_pc = squash_pc;
            m_q.delete();
            if (m_outstanding && !icache_resp_valid) begin
               m_discard = 1'b1;
            end else begin
               m_outstanding = 1'b0;
               m_discard     = 1'b0;
            end
         end else begin
            pre_out = m_outstanding;
            repeat (exp_num) void'(m_q.pop_front());
            m_pc = m_pc + 32'(4 * exp_num);
            if (exp_valid && icache_req_ready) m_outstanding = 1'b1;
            if (pre_out && icache_resp_valid) begin
               if (!m_discard) begin
                  base = {m_pc[31:3], 3'b000};
                  for (int w = int'(m_pc[2]); w < 2; w++) begin
                     m_q.push_back('{inst: icache_resp_data[32*w +: 32],
                                     pc: base + 32'(4 * w)});
                  end
               end
               m_outstanding = 1'b0;
               m_discard     = 1'b0;
            end
         end
      end
   end

   // One clock step; inputs change just after the rising edge.
   task automatic apply_stimulus();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset             = 1'b1;
      squash            = 1'b0;
      squash_pc         = 32'h0;
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b0;
      icache_resp_data  = 64'h0;
      open_entries      = CW'(8);

      repeat (2) apply_stimulus();
      settle();
      check_output("in reset req_valid", icache_req_valid, 1'b0);
      check_output("in reset num_accept", num_accept, '0);

      // Release reset; cache not ready for four cycles, address must hold.
      apply_stimulus();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         settle();
         check_output("stall req_valid", icache_req_valid, 1'b1);
         check_output("stall req_addr", icache_req_addr, 32'h0);
         apply_stimulus();
      end
      icache_req_ready = 1'b1;
      settle();
      check_output("first req_addr", icache_req_addr, 32'h0);

      apply_stimulus();
      icache_req_ready = 1'b0;
      settle();
      check_output("wait req_valid", icache_req_valid, 1'b0);

      apply_stimulus();
      icache_resp_valid = 1'b1;
      icache_resp_data  = 64'hBBBB0002_AAAA0001;

      apply_stimulus();
      icache_resp_valid = 1'b0;
      icache_resp_data  = 64'h0;
      settle();
      check_output("line0 num_accept", num_accept, 4'd2);
      check_output("line0 pkt0", out_insts[0], mk(32'hAAAA0001, 32'h0, 32'h4));
      check_output("line0 pkt1", out_insts[1], mk(32'hBBBB0002, 32'h4, 32'h8));
      check_output("line0 pkt2", out_insts[2], '0);

      apply_stimulus();
      icache_req_ready = 1'b1;
      settle();
      check_output("next req_addr", icache_req_addr, 32'h8);

      // Squash while delivering.
      apply_stimulus();
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_data  = 64'hDDDD0004_CCCC0003;

      apply_stimulus();
      icache_resp_valid = 1'b0;
      squash            = 1'b1;
      squash_pc         = 32'h104;
      settle();
      check_output("squash num_accept", num_accept, '0);

      apply_stimulus();
      squash           = 1'b0;
      icache_req_ready = 1'b1;
      settle();
      check_output("redirect req_addr", icache_req_addr, 32'h100);

      apply_stimulus();
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_data  = 64'h00005104_00005100;

      apply_stimulus();
      icache_resp_valid = 1'b0;
      settle();
      check_output("odd slot num_accept", num_accept, 4'd1);
      check_output("odd slot pkt0", out_insts[0], mk(32'h00005104, 32'h104, 32'h108));
      check_output("odd slot pkt1", out_insts[1], '0);

      // Back to PC 0, then deliver with no buffer room.
      apply_stimulus();
      squash    = 1'b1;
      squash_pc = 32'h0;
      apply_stimulus();
      squash           = 1'b0;
      icache_req_ready = 1'b1;
      settle();
      check_output("pc0 req_addr", icache_req_addr, 32'h0);

      apply_stimulus();
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_data  = 64'h0000F004_0000F000;
      open_entries      = '0;

      apply_stimulus();
      icache_resp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check_output("full num_accept", num_accept, '0);
         apply_stimulus();
      end
      open_entries = CW'(1);
      settle();
      check_output("room1 num_accept", num_accept, 4'd1);
      check_output("room1 pkt0", out_insts[0], mk(32'h0000F000, 32'h0, 32'h4));
      apply_stimulus();
      settle();
      check_output("room1b pkt0", out_insts[0], mk(32'h0000F004, 32'h4, 32'h8));

      apply_stimulus();
      open_entries     = CW'(8);
      icache_req_ready = 1'b1;
      settle();
      check_output("after room req_addr", icache_req_addr, 32'h8);

      // Squash in WAIT with no response: drain the stale line.
      apply_stimulus();
      icache_req_ready = 1'b0;
      squash           = 1'b1;
      squash_pc        = 32'h200;
      apply_stimulus();
      squash            = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_data  = 64'hDEADDEAD_DEADDEAD;
      settle();
      check_output("drain req_valid", icache_req_valid, 1'b0);
      check_output("drain num_accept", num_accept, '0);
      apply_stimulus();
      icache_resp_valid = 1'b0;
      icache_req_ready  = 1'b1;
      settle();
      check_output("post drain req_addr", icache_req_addr, 32'h200);

      // Async reset pulse in the middle of a delivering cycle.
      apply_stimulus();
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_data  = 64'h0000A204_0000A200;
      apply_stimulus();
      icache_resp_valid = 1'b0;
      settle();
      check_output("pre reset num_accept", num_accept, 4'd2);
      #1;
      reset = 1'b1;
      #1;
      check_output("async reset num_accept", num_accept, '0);
      check_output("async reset pkt0", out_insts[0], '0);
      check_output("async reset req_valid", icache_req_valid, 1'b0);
      apply_stimulus();
      reset = 1'b0;
      settle();
      check_output("after reset req_addr", icache_req_addr, 32'h0);

      // PC wrap at the top of the address space.
      apply_stimulus();
      squash    = 1'b1;
      squash_pc = 32'hFFFF_FFF8;
      apply_stimulus();
      squash           = 1'b0;
      icache_req_ready = 1'b1;
      settle();
      check_output("wrap req_addr", icache_req_addr, 32'hFFFF_FFF8);
      apply_stimulus();
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_data  = 64'h0000BEEF_0000CAFE;
      apply_stimulus();
      icache_resp_valid = 1'b0;
      settle();
      check_output("wrap pkt0", out_insts[0], mk(32'h0000CAFE, 32'hFFFF_FFF8, 32'hFFFF_FFFC));
      check_output("wrap pkt1", out_insts[1], mk(32'h0000BEEF, 32'hFFFF_FFFC, 32'h0));
      apply_stimulus();
      icache_req_ready = 1'b1;
      settle();
      check_output("wrapped req_addr", icache_req_addr, 32'h0);

      // Repeated squashes while draining; the response ends the drain.
      apply_stimulus();
      icache_req_ready = 1'b0;
      squash           = 1'b1;
      squash_pc        = 32'h300;
      apply_stimulus();
      squash_pc = 32'h400;
      settle();
      check_output("drain2 req_valid", icache_req_valid, 1'b0);
      apply_stimulus();
      squash_pc         = 32'h500;
      icache_resp_valid = 1'b1;
      apply_stimulus();
      squash            = 1'b0;
      icache_resp_valid = 1'b0;
      settle();
      check_output("drain2 exit req_addr", icache_req_addr, 32'h500);
      check_output("drain2 exit req_valid", icache_req_valid, 1'b1);

      repeat (2) apply_stimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
